// File: rtl/crossbar_transfer_ctrl_pkg.sv
// Shared types and helpers for the crossbar transfer controller.
// Holds the default sizes, the per-input FSM encoding and small utilities.
package crossbar_transfer_ctrl_pkg;

    localparam int N_DEF     = 8;
    localparam int P_DEF     = 4;
    localparam int WIDTH_DEF = 32;
    localparam int FRAME_DEF = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } xfer_state_e;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/crossbar_transfer_ctrl_xfer_port_fsm.sv
// Per-input transfer FSM: one-cycle VPQ read, then busy for a frame time.
// Latches the granted output and priority for the duration of the frame.
module xfer_port_fsm
    import crossbar_transfer_ctrl_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int P            = P_DEF,
    parameter int FRAME_CYCLES = FRAME_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_accept,
    input  logic [N-1:0] i_port,
    input  logic [P-1:0] i_pri,
    output logic         o_rd,
    output logic         o_done,
    output logic         o_busy,
    output logic [N-1:0] o_port,
    output logic [P-1:0] o_pri
);

    localparam int CW = (clog2(FRAME_CYCLES) > 0) ? clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    xfer_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rd;
    logic          r_done;
    logic          r_busy;
    logic [N-1:0]  r_port;
    logic [P-1:0]  r_pri;

    // IDLE waits for an accepted grant; XFER counts down the frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_port  <= '0;
            r_pri   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rd   <= 1'b0;
                    r_done <= 1'b0;
                    if (i_accept) begin
                        r_state <= ST_XFER;
                        r_rd    <= 1'b1;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_port  <= i_port;
                        r_pri   <= i_pri;
                        r_done  <= (FRAME_CYCLES == 1);
                    end
                end
                ST_XFER: begin
                    r_rd <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_port  <= '0;
                        r_pri   <= '0;
                    end else begin
                        r_cnt  <= r_cnt - CNT_ONE;
                        r_done <= (r_cnt == CNT_ONE);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rd   = r_rd;
    assign o_done = r_done;
    assign o_busy = r_busy;
    assign o_port = r_port;
    assign o_pri  = r_pri;

endmodule

// File: rtl/crossbar_transfer_ctrl.sv
// Crossbar transfer controller: turns scheduler grants into VPQ reads and busy.
// Optional per-output frame counters are built when XFER_STATS_EN is defined.
module crossbar_transfer_ctrl
    import crossbar_transfer_ctrl_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int P            = P_DEF,
    parameter int WIDTH        = WIDTH_DEF,
    parameter int FRAME_CYCLES = FRAME_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N*N-1:0]   i_acc_grant,
    input  logic [N*P-1:0]   i_acc_pri,
    output logic [N-1:0]     o_rd,
    output logic [N*N-1:0]   o_rd_port,
    output logic [N*P-1:0]   o_rd_pri,
    output logic [N-1:0]     o_in_busy,
    output logic [N-1:0]     o_out_busy,
    output logic [N-1:0]     o_xfer_done,
    output logic             o_err,
    output logic [N*WIDTH-1:0] o_xfer_cnt
);

    logic [N-1:0] w_busy;
    logic [N-1:0] w_done;
    logic [N-1:0] w_rd;
    logic [N-1:0] w_port [N];
    logic [P-1:0] w_pri  [N];
    logic [N-1:0] w_nz;
    logic [N-1:0] w_cand;
    logic [N-1:0] w_accept;
    logic [N-1:0] w_out_busy;
    logic         r_err;

    // Output is busy when any transferring input holds it.
    always_comb begin
        w_out_busy = '0;
        for (int i = 0; i < N; i++) begin
            if (w_busy[i]) w_out_busy = w_out_busy | w_port[i];
        end
    end

    // Legality per input, then lowest-index wins each output.
    always_comb begin
        w_nz     = '0;
        w_cand   = '0;
        w_accept = '0;
        for (int i = 0; i < N; i++) begin
            w_nz[i]   = |i_acc_grant[i*N +: N];
            w_cand[i] = is_onehot(64'(i_acc_grant[i*N +: N]))
                        && !w_busy[i]
                        && ((i_acc_grant[i*N +: N] & w_out_busy) == '0);
        end
        for (int i = 0; i < N; i++) begin
            w_accept[i] = w_cand[i];
            for (int k = 0; k < N; k++) begin
                if (k < i && w_cand[k]
                    && i_acc_grant[k*N +: N] == i_acc_grant[i*N +: N])
                    w_accept[i] = 1'b0;
            end
        end
    end

    // Any nonzero row that was not accepted is a rejected grant.
    always_ff @(posedge clk) begin
        if (!reset) r_err <= 1'b0;
        else        r_err <= |(w_nz & ~w_accept);
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_port
        xfer_port_fsm #(
            .N            (N),
            .P            (P),
            .FRAME_CYCLES (FRAME_CYCLES)
        ) u_fsm (
            .clk      (clk),
            .reset    (reset),
            .i_accept (w_accept[gi]),
            .i_port   (i_acc_grant[gi*N +: N]),
            .i_pri    (i_acc_pri[gi*P +: P]),
            .o_rd     (w_rd[gi]),
            .o_done   (w_done[gi]),
            .o_busy   (w_busy[gi]),
            .o_port   (w_port[gi]),
            .o_pri    (w_pri[gi])
        );
        assign o_rd_port[gi*N +: N] = w_port[gi];
        assign o_rd_pri[gi*P +: P]  = w_pri[gi];
    end

    assign o_rd        = w_rd;
    assign o_in_busy   = w_busy;
    assign o_out_busy  = w_out_busy;
    assign o_xfer_done = w_done;
    assign o_err       = r_err;

`ifdef XFER_STATS_EN
    logic [N-1:0]     w_cnt_inc;
    logic [WIDTH-1:0] r_cnt [N];

    // An output's count steps when the input holding it finishes.
    always_comb begin
        w_cnt_inc = '0;
        for (int i = 0; i < N; i++) begin
            if (w_done[i]) w_cnt_inc = w_cnt_inc | w_port[i];
        end
    end

    // Free-running per-output frame counters, wrapping naturally.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (!reset)           r_cnt[j] <= '0;
            else if (w_cnt_inc[j]) r_cnt[j] <= r_cnt[j] + 1'b1;
        end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_cnt
        assign o_xfer_cnt[gj*WIDTH +: WIDTH] = r_cnt[gj];
    end
`else
    assign o_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_crossbar_transfer_ctrl.sv
// Directed bench for crossbar_transfer_ctrl (FRAME_CYCLES=4 and =1 builds).
// Build with XFER_STATS_EN defined to also cover the frame counters.
module tb_crossbar_transfer_ctrl;

    localparam int N = 8;
    localparam int P = 4;
    localparam int W = 32;

`ifdef XFER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N*N-1:0] grant = '0;
    logic [N*P-1:0] pri = '0;
    logic [N-1:0]   rd, in_busy, out_busy, done;
    logic [N*N-1:0] rd_port;
    logic [N*P-1:0] rd_pri;
    logic           err;
    logic [N*W-1:0] xcnt;

    logic [N*N-1:0] g1 = '0;
    logic [N*P-1:0] p1 = '0;
    logic [N-1:0]   rd1, in_busy1, out_busy1, done1;
    logic [N*N-1:0] rd_port1;
    logic [N*P-1:0] rd_pri1;
    logic           err1;
    logic [N*W-1:0] xcnt1;

    int errors = 0;
    int checks = 0;

    crossbar_transfer_ctrl #(
        .N(N), .P(P), .WIDTH(W), .FRAME_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .i_acc_grant(grant), .i_acc_pri(pri),
        .o_rd(rd), .o_rd_port(rd_port), .o_rd_pri(rd_pri),
        .o_in_busy(in_busy), .o_out_busy(out_busy),
        .o_xfer_done(done), .o_err(err), .o_xfer_cnt(xcnt)
    );

    crossbar_transfer_ctrl #(
        .N(N), .P(P), .WIDTH(W), .FRAME_CYCLES(1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .i_acc_grant(g1), .i_acc_pri(p1),
        .o_rd(rd1), .o_rd_port(rd_port1), .o_rd_pri(rd_pri1),
        .o_in_busy(in_busy1), .o_out_busy(out_busy1),
        .o_xfer_done(done1), .o_err(err1), .o_xfer_cnt(xcnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({rd, in_busy, out_busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outs got=%h exp=0",
                     {rd, in_busy, out_busy, done, err});
        end
        checks++;
        if ({rd_port, rd_pri, xcnt} !== '0) begin
            errors++;
            $display("FAIL reset_rows got=%h exp=0", {rd_port, rd_pri, xcnt});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [N-1:0] exp_done;
        grant[2*N +: N] = 8'h20;
        pri[2*P +: P]   = 4'b0100;
        step();
        grant = '0;
        pri   = '0;
        checks++;
        if (rd !== 8'h04) begin
            errors++;
            $display("FAIL single_rd got=%h exp=04", rd);
        end
        checks++;
        if (rd_pri[2*P +: P] !== 4'b0100) begin
            errors++;
            $display("FAIL single_pri got=%b exp=0100", rd_pri[2*P +: P]);
        end
        checks++;
        if (rd_port[2*N +: N] !== 8'h20) begin
            errors++;
            $display("FAIL single_port got=%h exp=20", rd_port[2*N +: N]);
        end
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            exp_done = (c == 4) ? 8'h04 : 8'h00;
            checks++;
            if (in_busy !== 8'h04 || out_busy !== 8'h20) begin
                errors++;
                $display("FAIL single_busy c=%0d got=%h/%h exp=04/20",
                         c, in_busy, out_busy);
            end
            checks++;
            if (done !== exp_done || err !== 1'b0) begin
                errors++;
                $display("FAIL single_done c=%0d got=%h/%b exp=%h/0",
                         c, done, err, exp_done);
            end
            if (c > 1) begin
                checks++;
                if (rd !== 8'h00) begin
                    errors++;
                    $display("FAIL single_rd_once c=%0d got=%h exp=00", c, rd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_cnt;
        step();
        checks++;
        if (in_busy !== 8'h00 || done !== 8'h00 || rd_port !== '0) begin
            errors++;
            $display("FAIL b2b_drop got=%h/%h exp=00/00", in_busy, done);
        end
        grant[2*N +: N] = 8'h20;
        pri[2*P +: P]   = 4'b0001;
        step();
        grant = '0;
        pri   = '0;
        checks++;
        if (rd !== 8'h04 || in_busy !== 8'h04) begin
            errors++;
            $display("FAIL b2b_rd got=%h/%h exp=04/04", rd, in_busy);
        end
        checks++;
        if (rd_pri[2*P +: P] !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_pri got=%b exp=0001", rd_pri[2*P +: P]);
        end
        step();
        step();
        step();
        checks++;
        if (done !== 8'h04) begin
            errors++;
            $display("FAIL b2b_done got=%h exp=04", done);
        end
        step();
        exp_cnt = (STATS != 0) ? 32'd2 : 32'd0;
        checks++;
        if (xcnt[5*W +: W] !== exp_cnt || xcnt[0 +: W] !== '0) begin
            errors++;
            $display("FAIL b2b_cnt got=%0d exp=%0d", xcnt[5*W +: W], exp_cnt);
        end
    endtask

    task automatic test_collision();
        grant[1*N +: N] = 8'h01;
        grant[3*N +: N] = 8'h01;
        step();
        grant = '0;
        checks++;
        if (rd !== 8'h02 || in_busy !== 8'h02 || out_busy !== 8'h01) begin
            errors++;
            $display("FAIL coll_win got=%h/%h/%h exp=02/02/01",
                     rd, in_busy, out_busy);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL coll_err got=%b exp=1", err);
        end
        step();
        checks++;
        if (err !== 1'b0 || rd !== 8'h00) begin
            errors++;
            $display("FAIL coll_err_once got=%b/%h exp=0/00", err, rd);
        end
        step();
        step();
        step();
        checks++;
        if (in_busy !== 8'h00 || out_busy !== 8'h00) begin
            errors++;
            $display("FAIL coll_idle got=%h/%h exp=00/00", in_busy, out_busy);
        end
    endtask

    task automatic test_illegal();
        grant[4*N +: N] = 8'h06;
        step();
        grant = '0;
        checks++;
        if (rd !== 8'h00 || err !== 1'b1 || in_busy !== 8'h00) begin
            errors++;
            $display("FAIL ill_multi got=%h/%b/%h exp=00/1/00",
                     rd, err, in_busy);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ill_err_clear got=%b exp=0", err);
        end
        grant[2*N +: N] = 8'h20;
        step();
        grant[2*N +: N] = 8'h00;
        grant[4*N +: N] = 8'h20;
        step();
        grant = '0;
        checks++;
        if (rd !== 8'h00 || err !== 1'b1 || in_busy !== 8'h04
            || out_busy !== 8'h20) begin
            errors++;
            $display("FAIL ill_busy_out got=%h/%b/%h/%h exp=00/1/04/20",
                     rd, err, in_busy, out_busy);
        end
        grant[2*N +: N] = 8'h02;
        step();
        grant = '0;
        checks++;
        if (err !== 1'b1 || rd_port[2*N +: N] !== 8'h20) begin
            errors++;
            $display("FAIL ill_in_xfer got=%b/%h exp=1/20",
                     err, rd_port[2*N +: N]);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ill_zero_row got=%b exp=0", err);
        end
        step();
        checks++;
        if (in_busy !== 8'h00) begin
            errors++;
            $display("FAIL ill_idle got=%h exp=00", in_busy);
        end
    endtask

    task automatic test_reset_mid();
        grant[0 +: N] = 8'h02;
        step();
        grant = '0;
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({rd, in_busy, out_busy, done, err} !== '0) begin
            errors++;
            $display("FAIL rmid_outs got=%h exp=0",
                     {rd, in_busy, out_busy, done, err});
        end
        checks++;
        if ({rd_port, rd_pri, xcnt} !== '0) begin
            errors++;
            $display("FAIL rmid_rows got=%h exp=0", {rd_port, rd_pri, xcnt});
        end
        reset = 1'b1;
        grant[0 +: N] = 8'h02;
        step();
        grant = '0;
        checks++;
        if (rd !== 8'h01 || in_busy !== 8'h01 || out_busy !== 8'h02) begin
            errors++;
            $display("FAIL rmid_fresh got=%h/%h/%h exp=01/01/02",
                     rd, in_busy, out_busy);
        end
        for (int c = 0; c < 4; c++) step();
    endtask

    task automatic test_frame1();
        g1[7*N +: N] = 8'h80;
        p1[7*P +: P] = 4'b1000;
        step();
        g1 = '0;
        p1 = '0;
        checks++;
        if (rd1 !== 8'h80 || done1 !== 8'h80) begin
            errors++;
            $display("FAIL f1_rd_done got=%h/%h exp=80/80", rd1, done1);
        end
        checks++;
        if (in_busy1 !== 8'h80 || out_busy1 !== 8'h80
            || rd_pri1[7*P +: P] !== 4'b1000) begin
            errors++;
            $display("FAIL f1_busy got=%h/%h exp=80/80", in_busy1, out_busy1);
        end
        step();
        checks++;
        if ({rd1, done1, in_busy1, out_busy1, err1} !== '0) begin
            errors++;
            $display("FAIL f1_end got=%h exp=0",
                     {rd1, done1, in_busy1, out_busy1, err1});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_collision();
        test_illegal();
        test_reset_mid();
        test_frame1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crossbar_transfer_ctrl.md
Name: crossbar_transfer_ctrl

Overview:
- Downstream of the fiSLIP scheduler; consumes its accept/grant matrix and accepted priorities.
- Per input: issues a one-cycle read to the input's virtual priority queues, then holds the input and the granted output busy for one frame time.
- Produces in_busy/out_busy, which are fed back (inverted) to the scheduler's idle inputs.
- Synthesizable replacement for the per-port behavioural delivery models; polices grant legality.

Parameters:
N, 8, number of ports (inputs = outputs)
P, 4, number of priority levels
WIDTH, 32, width of statistics counters
FRAME_CYCLES, 64, clock cycles a frame occupies the crossbar (>= 1)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
i_acc_grant  in  N*N  row i = bits [i*N +: N]; bit j set = input i matched to output j; one-hot or zero
i_acc_pri  in  N*P  row i = bits [i*P +: P]; one-hot accepted priority for input i
o_rd  out  N  one-cycle read strobe per input to its VPQ
o_rd_port  out  N*N  row i = latched output one-hot of input i, valid while busy
o_rd_pri  out  N*P  row i = latched priority one-hot, valid while busy
o_in_busy  out  N  input i transferring
o_out_busy  out  N  output j being driven by some input
o_xfer_done  out  N  one-cycle pulse in the last busy cycle of input i
o_err  out  1  one-cycle pulse: at least one grant was rejected this cycle
o_xfer_cnt  out  N*WIDTH  completed frames per output (see Optional Feature)

Behaviour:
- Reset (reset==0 at an edge): all outputs 0, all per-input FSMs IDLE, counters 0. Applies mid-transfer; no done pulse is generated.
- Per-input FSM states: IDLE, XFER. Down-counter cnt has width clog2(FRAME_CYCLES).
- Accept, evaluated at edge t for each input i in IDLE:
  - Grant row nonzero and one-hot.
  - Target output j not o_out_busy.
  - No lower-index input accepting output j in the same cycle.
- On accept, at t+1:
  - State XFER; o_rd[i]=1 for exactly that cycle.
  - o_rd_port row latched from grant; o_rd_pri row latched from i_acc_pri unchanged.
  - cnt = FRAME_CYCLES-1; o_in_busy[i]=1; o_out_busy[j]=1.
- In XFER: cnt decrements each cycle. In the cycle cnt==0, o_xfer_done[i]=1. Next edge: IDLE, busy bits, o_rd_port row and o_rd_pri row cleared.
- Busy lasts exactly FRAME_CYCLES cycles.
- FRAME_CYCLES==1: o_rd and o_xfer_done assert in the same single cycle.
- Back-to-back: a grant sampled in the cycle after busy drops is accepted. Zero dead cycles are required beyond the scheduler's own latency.
- Rejections: the grant is dropped (no state change) and o_err pulses in the cycle after the sample. Causes:
  - Grant row not one-hot.
  - Grant while input in XFER.
  - Grant to a busy output.
  - Same-cycle output collision; the lowest index wins.
- A zero grant row is never an error.
- o_out_busy[j] = OR over inputs of (busy_i AND port_i[j]); combinational from registered state.

Optional Feature:
- Macro XFER_STATS_EN.
- Defined: o_xfer_cnt[j*WIDTH +: WIDTH] increments on each o_xfer_done of the input holding output j. Wraps modulo 2^WIDTH. Cleared on reset.
- Undefined: o_xfer_cnt tied to 0; no counter flops.

Decomposition:
- Shared package: N, P, FRAME_CYCLES defaults; the IDLE/XFER state encoding; onehot-check and clog2 functions.
- Sub-module xfer_port_fsm: one per input (generate loop). Holds state, cnt, latched port/pri, rd/done/busy.
- Top level: per-output lowest-index collision resolution, out_busy OR-reduction, error aggregation, optional stats.

Test Plan (N=8, P=4, FRAME_CYCLES=4):
- Single grant: input 2 to output 5, pri 0100, for 1 cycle -> next cycle o_rd=0x04, o_rd_pri row2=0100; in_busy[2] and out_busy[5] high 4 cycles; xfer_done[2] pulses in the 4th; o_err never.
- Back-to-back: regrant input 2 to output 5 the cycle busy drops -> new o_rd exactly 1 cycle later; busy gap of 1 cycle; o_xfer_cnt[5]=2 (stats enabled).
- Collision: inputs 1 and 3 both to output 0 in the same cycle -> only input 1 reads; o_err pulses once; in_busy=0x02.
- Illegal rows: input 4 row 0x06, then a grant to busy output 5 -> no o_rd[4], o_err pulse for each, state unchanged.
- Reset mid-transfer: reset low at cnt=2 -> next cycle all busy/rd/done 0, counters 0; a fresh grant after release is accepted normally.
- FRAME_CYCLES=1 rebuild: grant input 7 to output 7 -> o_rd[7] and xfer_done[7] in the same single cycle, busy for 1 cycle.
